// File: rtl/mem_stage_if.sv
// Port bundle of the memory-access stage: execute-side handshake, write-back
// handshake, data-SRAM response, flush inputs and the feedback buses.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 77,
  parameter int MS_TO_WS_BUS_WD = 70
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       wb_exc;
  logic                       wb_ertn;
  logic                       ms_to_es_ls_cancel;
  logic [38:0]                ms_fwd_blk_bus;

  // The stage itself.
  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
    input  data_sram_data_ok, data_sram_rdata, wb_exc, wb_ertn,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
    output ms_to_es_ls_cancel, ms_fwd_blk_bus
  );

  // Surrounding pipeline / environment.
  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus,
    output data_sram_data_ok, data_sram_rdata, wb_exc, wb_ertn,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
    input  ms_to_es_ls_cancel, ms_fwd_blk_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, extends load
// data, discards responses of flushed requests and feeds forwarding info back.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 77,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  pipe
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       buf_valid;
  logic [31:0]                rdata_buf;
  logic [1:0]                 drop_cnt;

  logic        ls_cancel;
  logic [4:0]  load_op;
  logic        mem_we;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;

  logic        flush;
  logic        is_mem;
  logic        need_data;
  logic        resp_ok;
  logic        ready_go;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic        leave;
  logic        orphan;
  logic        drop_dec;
  logic [31:0] load_data;
  logic [31:0] final_result;

  function automatic logic [31:0] load_extend(input logic [4:0]  op,
                                              input logic [1:0]  a,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    r = d;
    if (op[4])      r = {{24{b[7]}}, b};
    else if (op[3]) r = {{16{h[15]}}, h};
    else if (op[1]) r = {24'd0, b};
    else if (op[0]) r = {16'd0, h};
    return r;
  endfunction

  // Up/down count of orphaned requests, pinned to [0,3].
  function automatic logic [1:0] drop_next(input logic [1:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
    logic [1:0] n;
    n = cnt;
    if (inc && !dec && cnt != 2'd3)      n = cnt + 2'd1;
    else if (dec && !inc && cnt != 2'd0) n = cnt - 2'd1;
    return n;
  endfunction

  assign {ls_cancel, load_op, mem_we, gr_we, dest, result, pc} = bus_r;

  assign flush     = pipe.wb_exc | pipe.wb_ertn;
  assign is_mem    = (|load_op) | mem_we;
  assign need_data = ms_valid & is_mem & ~ls_cancel;
  assign resp_ok   = pipe.data_sram_data_ok & (drop_cnt == 2'd0);
  assign ready_go  = ~need_data | buf_valid | resp_ok;

  assign ms_allowin     = ~ms_valid | (ready_go & pipe.ws_allowin);
  assign ms_to_ws_valid = ms_valid & ready_go & ~flush;
  assign leave          = ms_to_ws_valid & pipe.ws_allowin;

  // A request still in flight when the flush hits will answer later; count it.
  assign orphan   = flush & need_data & ~buf_valid & ~resp_ok;
  assign drop_dec = pipe.data_sram_data_ok & (drop_cnt != 2'd0);

  assign load_data    = buf_valid ? rdata_buf : pipe.data_sram_rdata;
  assign final_result = ((|load_op) & ~ls_cancel) ?
                        load_extend(load_op, result[1:0], load_data) : result;

  assign pipe.ms_allowin         = ms_allowin;
  assign pipe.ms_to_ws_valid     = ms_to_ws_valid;
  assign pipe.ms_to_ws_bus       = {gr_we, dest, final_result, pc};
  assign pipe.ms_to_es_ls_cancel = ms_valid & ls_cancel;
  assign pipe.ms_fwd_blk_bus     = {ms_valid & gr_we,
                                    ms_valid & (|load_op) & ~ls_cancel & ~ready_go,
                                    dest, final_result};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      bus_r     <= '0;
      buf_valid <= 1'b0;
      rdata_buf <= '0;
      drop_cnt  <= '0;
    end else begin
      if (flush)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= pipe.es_to_ms_valid;

      if (ms_allowin && pipe.es_to_ms_valid) bus_r <= pipe.es_to_ms_bus;

      // Hold the response when write-back stalls so data_ok need not repeat.
      if (flush || leave) begin
        buf_valid <= 1'b0;
      end else if (resp_ok && need_data && !buf_valid) begin
        buf_valid <= 1'b1;
        rdata_buf <= pipe.data_sram_rdata;
      end

      drop_cnt <= drop_next(drop_cnt, orphan, drop_dec);
    end
  end

endmodule
